word_rx: RTL

- Receive-side counterpart of the word serializer.
- Collects four consecutive bytes from the UART receiver into one 32-bit word, least-significant byte first, and presents the word to the consumer with a valid/ready handshake.
- Sits between uart_rx and any core logic that consumes 32-bit words, such as the program loader or the debug command path.
- Drops partial words after an inter-byte timeout, and flags words lost because the consumer stalled.

---
 rtl/uart_word_pkg.sv | 30 +++
 rtl/word_rx_if.sv | 49 ++++
 rtl/idle_timer.sv | 58 +++++
 rtl/word_rx.sv | 134 +++++++++++++
 4 files changed

// File: rtl/uart_word_pkg.sv
// ---------------------------------------------------------------------------
// uart_word_pkg
//   Shared definitions for the UART word-level blocks (word_rx today, a
//   word_tx cleanup later).
//
//   Contents:
//     BYTES_PER_WORD  bytes packed into one 32-bit word
//     COUNT_W         width of the byte counter (holds 0..BYTES_PER_WORD)
//     rx_state_t      word collection state: IDLE (no bytes held) or
//                     COLLECT (1..3 bytes held)
//     is_last_byte()  true when the byte about to be stored completes a word
// ---------------------------------------------------------------------------
package uart_word_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int COUNT_W        = 3;

    typedef enum logic {
        IDLE,
        COLLECT
    } rx_state_t;

    // cnt is the number of bytes already held before the current byte.
    function automatic logic is_last_byte(input logic [COUNT_W-1:0] cnt);
        return cnt == COUNT_W'(BYTES_PER_WORD - 1);
    endfunction

endpackage

// File: rtl/word_rx_if.sv
// ---------------------------------------------------------------------------
// word_rx_if
//   Bundles the byte input from uart_rx and the 32-bit word handshake to the
//   consumer.
//
//   Signals:
//     in       [7:0]  received byte from uart_rx
//     recv            one-cycle strobe, `in` valid in that cycle
//     out      [31:0] assembled word
//     valid           word available, held until accepted
//     ready           consumer accepts on valid && ready
//     overrun         pulse: completed word dropped, previous still pending
//     timeout         pulse: partial word discarded after inter-byte idle
//
//   Modports:
//     master  the word assembler (drives out/valid/overrun/timeout)
//     slave   the environment: byte source plus word consumer
// ---------------------------------------------------------------------------
interface word_rx_if;

    logic [7:0]  in;
    logic        recv;
    logic [31:0] out;
    logic        valid;
    logic        ready;
    logic        overrun;
    logic        timeout;

    modport master (
        input  in,
        input  recv,
        input  ready,
        output out,
        output valid,
        output overrun,
        output timeout
    );

    modport slave (
        output in,
        output recv,
        output ready,
        input  out,
        input  valid,
        input  overrun,
        input  timeout
    );

endinterface

// File: rtl/idle_timer.sv
// ---------------------------------------------------------------------------
// idle_timer
//   Counts idle clock cycles while `run` is high and flags the cycle in which
//   the idle period reaches TIMEOUT_CYCLES. Registers update on the falling
//   edge of clk, matching the rest of the UART pipeline.
//
//   Parameters:
//     TIMEOUT_CYCLES  idle cycles tolerated; 0 removes the timer entirely
//
//   Ports:
//     clk     in   clock (falling-edge active)
//     rst_n   in   asynchronous active-low reset
//     run     in   count only while high; counter clears while low
//     clear   in   activity in this cycle; restarts the idle period
//     expire  out  combinational, high in the cycle that ends the idle period
// ---------------------------------------------------------------------------
module idle_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expire
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled

            assign expire = 1'b0;

            logic unused_inputs;
            assign unused_inputs = ^{clk, rst_n, run, clear};

        end else begin : g_enabled

            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] idle_count;

            // Activity in the final cycle wins, so expiry requires no clear.
            assign expire = run && !clear && (idle_count == LAST);

            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    idle_count <= '0;
                end else if (!run || clear || expire) begin
                    idle_count <= '0;
                end else begin
                    idle_count <= idle_count + CW'(1);
                end
            end

        end
    endgenerate

endmodule

// File: rtl/word_rx.sv
// ---------------------------------------------------------------------------
// word_rx
//   Collects four bytes from uart_rx, least-significant byte first, into a
//   32-bit word and offers it to the consumer with a valid/ready handshake.
//   Collection continues while a word is pending, giving one word of
//   buffering; a word completed while the previous one is still pending is
//   dropped and flagged with `overrun`. A partial word idle for
//   TIMEOUT_CYCLES cycles is discarded and flagged with `timeout`.
//   All registers update on the falling edge of clk.
//
//   Parameters:
//     TIMEOUT_CYCLES  inter-byte idle limit in clk cycles; 0 disables it
//
//   Ports:
//     clk    in  clock (falling-edge active)
//     rst_n  in  asynchronous active-low reset
//     bus    word_rx_if.master: in/recv from uart_rx, out/valid/ready to the
//            consumer, overrun/timeout status pulses
// ---------------------------------------------------------------------------
module word_rx
    import uart_word_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    word_rx_if.master  bus
);

    rx_state_t            state;
    rx_state_t            state_next;
    logic [COUNT_W-1:0]   count;
    logic [WORD_W-1:0]    assembly;

    logic                 store_byte;
    logic                 complete;
    logic                 load_word;
    logic                 drop_word;
    logic                 run_timer;
    logic                 expire;

    idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run_timer),
        .clear  (bus.recv),
        .expire (expire)
    );

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.recv) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.recv && is_last_byte(count)) begin
                    state_next = IDLE;
                end else if (expire) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // A finished word may load when the output slot is empty or is being
    // emptied on this very edge; otherwise it has nowhere to go.
    always_comb begin
        store_byte = 1'b0;
        complete   = 1'b0;
        run_timer  = 1'b0;
        case (state)
            IDLE: begin
                store_byte = bus.recv;
            end
            COLLECT: begin
                store_byte = bus.recv;
                run_timer  = 1'b1;
                complete   = bus.recv && is_last_byte(count);
            end
        endcase
        load_word = complete && (!bus.valid || bus.ready);
        drop_word = complete && !load_word;
    end

    // The fourth byte goes straight to the output, so only three bytes ever
    // sit in the assembly register and the count never rests at four.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            assembly <= '0;
        end else if (complete) begin
            count    <= '0;
        end else if (store_byte) begin
            assembly[{count[1:0], 3'b000} +: BYTE_W] <= bus.in;
            count                                    <= count + COUNT_W'(1);
        end else if (expire) begin
            count    <= '0;
            assembly <= '0;
        end
    end

    // A load on the same edge as an accept keeps valid high with the new word.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out     <= '0;
            bus.valid   <= 1'b0;
            bus.overrun <= 1'b0;
            bus.timeout <= 1'b0;
        end else begin
            bus.overrun <= drop_word;
            bus.timeout <= expire;
            if (load_word) begin
                bus.out   <= {bus.in, assembly[23:0]};
                bus.valid <= 1'b1;
            end else if (bus.valid && bus.ready) begin
                bus.valid <= 1'b0;
            end
        end
    end

endmodule
